// File: rtl/sr_drive_pkg.sv
// Shared state encoding and default timing constants for the SR latch driver.
package sr_drive_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SPULSE = 2'd1;
    localparam logic [1:0] ST_RPULSE = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    localparam int DEF_DB_CYCLES = 4;
    localparam int DEF_PULSE_W   = 2;
    localparam int DEF_GAP_W     = 1;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/sr_drive_ctrl_if.sv
// Request/pulse bundle between the request source and the SR latch driver.
interface sr_drive_ctrl_if;

    logic set_in;
    logic reset_in;
    logic sbar;
    logic rbar;
    logic busy;
    logic conflict;

    modport master (output set_in, reset_in, input sbar, rbar, busy, conflict);
    modport slave  (input set_in, reset_in, output sbar, rbar, busy, conflict);

endinterface

// File: rtl/sr_debounce.sv
// Counter-based debouncer: level flips after DB_CYCLES consecutive differing samples.
module sr_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rstbar,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstbar) begin
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (din == dout) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                // rise is a one-clock request, only for the 0->1 direction
                dout <= din;
                rise <= din;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sr_drive_ctrl.sv
// Debounced, reset-priority pulse driver for a NAND SR latch (sbar/rbar never low together).
// Optional 2-flop input synchroniser enabled by defining SR_DRIVE_SYNC_EN.
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int PULSE_W   = DEF_PULSE_W,
    parameter int GAP_W     = DEF_GAP_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input logic            clk,
    input logic            rstbar,
    sr_drive_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

    logic set_src, reset_src;
    logic set_req, reset_req;

`ifdef SR_DRIVE_SYNC_EN
    logic [1:0] set_sync, reset_sync;

    always_ff @(posedge clk) begin
        if (!rstbar) begin
            set_sync   <= 2'b00;
            reset_sync <= 2'b00;
        end else begin
            set_sync   <= {set_sync[0], bus.set_in};
            reset_sync <= {reset_sync[0], bus.reset_in};
        end
    end

    assign set_src   = set_sync[1];
    assign reset_src = reset_sync[1];
`else
    assign set_src   = bus.set_in;
    assign reset_src = bus.reset_in;
`endif

    sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_set (
        .clk(clk), .rstbar(rstbar), .din(set_src), .dout(), .rise(set_req)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_reset (
        .clk(clk), .rstbar(rstbar), .din(reset_src), .dout(), .rise(reset_req)
    );

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pend_s, pend_s_nx, pend_r, pend_r_nx;
    logic             conflict_nx, dispatch;
    logic             s_any, r_any;

    assign s_any = set_req | pend_s;
    assign r_any = reset_req | pend_r;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        pend_s_nx   = pend_s;
        pend_r_nx   = pend_r;
        conflict_nx = 1'b0;
        dispatch    = 1'b0;
        case (state)
            ST_IDLE: dispatch = 1'b1;
            ST_SPULSE, ST_RPULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nx = ST_GAP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                if (cnt == GAP_LAST) dispatch = 1'b1;
                else                 cnt_nx = cnt + CNT_W'(1);
            end
        endcase

        // IDLE and the last GAP clock both launch the next pulse, reset first
        if (dispatch) begin
            cnt_nx = '0;
            if (r_any) begin
                state_nx    = ST_RPULSE;
                pend_r_nx   = 1'b0;
                pend_s_nx   = 1'b0;
                conflict_nx = s_any;
            end else if (s_any) begin
                state_nx  = ST_SPULSE;
                pend_s_nx = 1'b0;
            end else begin
                state_nx = ST_IDLE;
            end
        end else begin
            if (set_req)   pend_s_nx = 1'b1;
            if (reset_req) pend_r_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstbar) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pend_s       <= 1'b0;
            pend_r       <= 1'b0;
            bus.sbar     <= 1'b1;
            bus.rbar     <= 1'b1;
            bus.busy     <= 1'b0;
            bus.conflict <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            pend_s       <= pend_s_nx;
            pend_r       <= pend_r_nx;
            bus.sbar     <= (state_nx != ST_SPULSE);
            bus.rbar     <= (state_nx != ST_RPULSE);
            bus.busy     <= (state_nx != ST_IDLE);
            bus.conflict <= conflict_nx;
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl with default parameters and the synchroniser disabled.
module tb_sr_drive_ctrl;

    logic clk = 1'b0;
    logic rstbar = 1'b0;

    sr_drive_ctrl_if bus ();

    sr_drive_ctrl dut (.clk(clk), .rstbar(rstbar), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic s;
        logic r;
        logic sb;
        logic rb;
        logic bz;
        logic cf;
    } vec_t;

    vec_t tbl[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0b required=%0b at t=%0t", name, act, exp, $time);
    endtask

    task automatic add(input logic s, input logic r, input logic sb, input logic rb,
                       input logic bz, input logic cf);
        vec_t v;
        v.s = s; v.r = r; v.sb = sb; v.rb = rb; v.bz = bz; v.cf = cf;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic sb, input logic rb,
                           input logic bz, input logic cf);
        chk({tag, ".sbar"}, bus.sbar, sb);
        chk({tag, ".rbar"}, bus.rbar, rb);
        chk({tag, ".busy"}, bus.busy, bz);
        chk({tag, ".conflict"}, bus.conflict, cf);
        chk({tag, ".never_both_low"}, bus.sbar | bus.rbar, 1'b1);
    endtask

    task automatic do_reset();
        rstbar = 1'b0;
        bus.set_in = 1'b0;
        bus.reset_in = 1'b0;
        step();
        step();
        chk_out("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        rstbar = 1'b1;
    endtask

    initial begin
        bus.set_in = 1'b0;
        bus.reset_in = 1'b0;

        // clean set: low after edges 4,5; gap after 6; idle after 7
        for (int i = 0; i < 4; i++) add(1, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 1, 0);
        add(1, 0, 0, 1, 1, 0);
        add(1, 0, 1, 1, 1, 0);
        add(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 0);
        // simultaneous rise: reset wins, conflict for one clock
        for (int i = 0; i < 4; i++) add(1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 0);
        // back-to-back: reset debounced mid set pulse, one gap clock, then rbar pulse
        add(1, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 0, 0);
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 0, 1, 1, 0);
        add(1, 1, 0, 1, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 1, 0, 1, 0);
        add(1, 1, 1, 0, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 0);

        // reset then idle for 20 clocks
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            chk_out("idle", 1'b1, 1'b1, 1'b0, 1'b0);
        end

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            bus.set_in = tbl[i].s;
            bus.reset_in = tbl[i].r;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].sb, tbl[i].rb, tbl[i].bz, tbl[i].cf);
        end

        // bounce reject: 1,0,1,1,0 never reaches four consecutive samples
        do_reset();
        begin
            logic [4:0] pat;
            pat = 5'b01101;
            for (int i = 0; i < 15; i++) begin
                bus.set_in = (i < 5) ? pat[i] : 1'b0;
                step();
                chk("bounce.sbar", bus.sbar, 1'b1);
                chk("bounce.busy", bus.busy, 1'b0);
                chk("bounce.deb", dut.u_db_set.dout, 1'b0);
            end
        end

        // mid-pulse reset aborts the pulse and nothing resumes afterwards
        do_reset();
        bus.set_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("midrst.pulse_low", bus.sbar, 1'b0);
        rstbar = 1'b0;
        bus.set_in = 1'b0;
        step();
        chk_out("midrst.abort", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst.state", dut.state == 2'd0, 1'b1);
        rstbar = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_out("midrst.after", 1'b1, 1'b1, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
- Upstream driver for the NAND SR latch: converts two raw, bouncy, level inputs (set request, reset request) into clean, fixed-width, active-low pulses on sbar/rbar.
- Guarantees the latch never sees sbar=0 and rbar=0 together, its forbidden input state.
- Enforces a guard gap between consecutive pulses.
- Reset requests have priority over set requests.

Parameters:
- DB_CYCLES, 4: consecutive samples a raw input must differ from its debounced value before the debounced value flips (≥1).
- PULSE_W, 2: clocks sbar or rbar is held low per pulse (≥1).
- GAP_W, 1: clocks both outputs are held high after each pulse, before the next may start (≥1).
- CNT_W, 8: counter width; must hold max(DB_CYCLES, PULSE_W, GAP_W).

Ports:
- clk  input  1  single clock, rising edge
- rstbar  input  1  synchronous active-low reset
- set_in  input  1  raw set request, active-high, asynchronous to clk
- reset_in  input  1  raw reset request, active-high, asynchronous to clk
- sbar  output  1  active-low set pulse to latch
- rbar  output  1  active-low reset pulse to latch
- busy  output  1  high whenever FSM is not in IDLE
- conflict  output  1  one-clock pulse when a set request is dropped because of a simultaneous reset request

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rstbar).
- Reset: rstbar sampled low at an edge forces, after that edge:
  - sbar=1, rbar=1, busy=0, conflict=0
  - debounced values 0, all counters 0, pending flags 0, state IDLE
  - Mid-pulse reset aborts the pulse; the latch keeps its state.
- Debounce (per input):
  - Counter increments each edge the raw input differs from the debounced value.
  - Counter clears on any edge where they match.
  - When the counter reaches DB_CYCLES, the debounced value takes the raw value and the counter clears.
- Request generation:
  - Debounced 0->1 transition = one request (set_req / reset_req). Falling transitions generate nothing.
  - An input held high through reset release generates a request after debouncing.
- Pending flags:
  - Requests arriving while busy set pend_s / pend_r. Only one of each is stored; extras are merged.
  - Flags clear when their request is serviced.
- FSM: IDLE, SPULSE, RPULSE, GAP.
  - IDLE: if a reset request (new or pending) exists -> RPULSE. Else if a set request exists -> SPULSE.
  - IDLE, simultaneous set and reset requests: -> RPULSE, set request discarded, conflict=1 for one clock.
  - SPULSE: sbar=0 for exactly PULSE_W clocks, then -> GAP.
  - RPULSE: rbar=0 for exactly PULSE_W clocks, then -> GAP.
  - GAP: both outputs high for GAP_W clocks, then -> IDLE.
  - In IDLE and GAP, sbar=rbar=1.
- Invariant: sbar|rbar == 1 on every clock.
- Pending set at GAP exit with a pending reset: the pending set is dropped and conflict pulses.
- Outputs are registered; no combinational path from inputs to outputs.
- Latency (defaults): raw input high and stable, first sampled at edge 0 -> debounced high after edge 3 -> output low after edge 4, high after edge 6, IDLE after edge 7.

Optional Feature:
- Macro SR_DRIVE_SYNC_EN.
- Defined: set_in and reset_in each pass through a 2-flop synchroniser (reset to 0) before debounce; latency +2 clocks.
- Undefined: raw inputs feed the debounce directly; the integrator guarantees synchronous inputs.

Decomposition:
- Package sr_drive_pkg holds:
  - the 2-bit state encoding (IDLE=0, SPULSE=1, RPULSE=2, GAP=3)
  - default constants for DB_CYCLES, PULSE_W, GAP_W, CNT_W
- Sub-module sr_debounce (parameters DB_CYCLES, CNT_W; ports clk, rstbar, din, dout, rise), instantiated once per input.
- FSM, pulse/gap counter and pending flags live in sr_drive_ctrl.

Test Plan:
- Reset then idle: rstbar=0 for 2 clocks, inputs 0 -> sbar=1, rbar=1, busy=0, conflict=0 for 20 clocks.
- Clean set: set_in high from edge 0 -> sbar=0 after edges 4 and 5 only, busy high edges 4-6, exactly one pulse.
- Bounce reject: set_in toggles 1,0,1,1,0 then stays 0 -> no pulse, debounced value stays 0.
- Simultaneous: set_in and reset_in rise together -> rbar pulse of 2 clocks, no sbar pulse, conflict=1 for exactly 1 clock, sbar|rbar never 0.
- Back-to-back: reset request debounced during an sbar pulse -> sbar pulse completes, 1 gap clock, then rbar low 2 clocks.
- Mid-pulse reset: rstbar=0 while sbar=0 -> sbar=1 after that edge, state IDLE, no resumed pulse after release with inputs 0.
